seg7_scan_mux: RTL and testbench

//   Downstream stage of the 7-seg CPU device. Takes the four per-digit segment

---
 rtl/seg7_scan_mux.sv | 98 +++++++++
 tb/tb_seg7_scan_mux.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 4-digit 7-segment scanner with per-slot blanking and per-frame input snapshot.
// Optional brightness PWM on the lit phase when SEG7_SCAN_DIM_EN is defined (adds port `bright`).
module seg7_scan_mux #(
  parameter int unsigned DIV   = 1000,
  parameter int unsigned BLANK = 16
) (
  input  logic       cpu_clk,
  input  logic       rst,
  input  logic [6:0] hex0,
  input  logic [6:0] hex1,
  input  logic [6:0] hex2,
  input  logic [6:0] hex3,
`ifdef SEG7_SCAN_DIM_EN
  input  logic [3:0] bright,
`endif
  output logic [6:0] seg,
  output logic [3:0] dig_en,
  output logic       frame_tick
);

  localparam logic [15:0] CNT_LAST  = 16'(DIV - 1);
  localparam logic [15:0] CNT_BLANK = 16'(BLANK);

  logic [15:0] cnt;
  logic [1:0]  idx;
  logic [6:0]  snap [4];
  logic        frame_start;
  logic        lit;
  logic [6:0]  seg_d;
  logic [3:0]  dig_en_d;

  // Frame start is the (0,0) scan position; the first edge after reset lands here too.
  assign frame_start = (idx == 2'd0) && (cnt == '0);

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) snap[i] <= '1;
    end else if (frame_start) begin
      snap[0] <= hex0;
      snap[1] <= hex1;
      snap[2] <= hex2;
      snap[3] <= hex3;
    end
  end

`ifdef SEG7_SCAN_DIM_EN
  logic [3:0] pwm;
  logic [3:0] bright_r;

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      pwm      <= '0;
      bright_r <= '1;
    end else begin
      pwm <= pwm + 4'd1;
      if (frame_start) bright_r <= bright;
    end
  end

  assign lit = (cnt >= CNT_BLANK) && (pwm <= bright_r);
`else
  assign lit = (cnt >= CNT_BLANK);
`endif

  always_comb begin
    seg_d    = '1;
    dig_en_d = '1;
    if (lit) begin
      seg_d    = snap[idx];
      dig_en_d = ~(4'b0001 << idx);
    end
  end

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      seg        <= '1;
      dig_en     <= '1;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_d;
      dig_en     <= dig_en_d;
      frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux: DIV=8/BLANK=2 and DIV=2/BLANK=1 instances, plus a
// bright=3 instance when SEG7_SCAN_DIM_EN is defined.
module tb_seg7_scan_mux;

  logic       cpu_clk = 1'b0;
  logic       rst;
  logic [6:0] hex [4];
  logic [6:0] seg_a, seg_b;
  logic [3:0] dig_a, dig_b;
  logic       tick_a, tick_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] snap_a [4];
  logic [6:0] snap_b [4];
  logic [3:0] prev_dig_a;

  always #5 cpu_clk = ~cpu_clk;

  seg7_scan_mux #(.DIV(8), .BLANK(2)) dut_a (
    .cpu_clk(cpu_clk), .rst(rst),
    .hex0(hex[0]), .hex1(hex[1]), .hex2(hex[2]), .hex3(hex[3]),
`ifdef SEG7_SCAN_DIM_EN
    .bright(4'hf),
`endif
    .seg(seg_a), .dig_en(dig_a), .frame_tick(tick_a)
  );

  seg7_scan_mux #(.DIV(2), .BLANK(1)) dut_b (
    .cpu_clk(cpu_clk), .rst(rst),
    .hex0(hex[0]), .hex1(hex[1]), .hex2(hex[2]), .hex3(hex[3]),
`ifdef SEG7_SCAN_DIM_EN
    .bright(4'hf),
`endif
    .seg(seg_b), .dig_en(dig_b), .frame_tick(tick_b)
  );

`ifdef SEG7_SCAN_DIM_EN
  logic [6:0] seg_c;
  logic [3:0] dig_c;
  logic       tick_c;

  seg7_scan_mux #(.DIV(8), .BLANK(2)) dut_c (
    .cpu_clk(cpu_clk), .rst(rst),
    .hex0(hex[0]), .hex1(hex[1]), .hex2(hex[2]), .hex3(hex[3]),
    .bright(4'h3),
    .seg(seg_c), .dig_en(dig_c), .frame_tick(tick_c)
  );
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // k is the edge number counted from the first edge after reset release.
  task automatic run_span(input int k_first, input int k_last);
    logic [3:0] one;
    logic [3:0] exp_dig;
    logic [6:0] exp_seg;
    int         c, s;
    bit         lit;
    one = 4'b0001;
    for (int k = k_first; k <= k_last; k++) begin
      if (k % 32 == 0) snap_a = hex;
      if (k % 8 == 0)  snap_b = hex;
      @(posedge cpu_clk);
      #1;
      c = k % 8;
      s = (k / 8) % 4;
      lit     = (c >= 2);
      exp_seg = lit ? snap_a[s] : 7'h7f;
      exp_dig = lit ? ~(one << s) : 4'hf;
      check_eq("a_seg", 32'(seg_a), 32'(exp_seg));
      check_eq("a_dig", 32'(dig_a), 32'(exp_dig));
      check_eq("a_tick", 32'(tick_a), 32'(k % 32 == 0));
      check_eq("a_onehot", 32'(dig_a == 4'hf || $countones(~dig_a) == 1), 32'd1);
      if (dig_a != 4'hf && prev_dig_a != 4'hf && dig_a != prev_dig_a)
        check_eq("a_overlap", 32'(prev_dig_a), 32'hf);
      prev_dig_a = dig_a;
`ifdef SEG7_SCAN_DIM_EN
      lit     = (c >= 2) && ((k % 16) <= 3);
      exp_seg = lit ? snap_a[s] : 7'h7f;
      exp_dig = lit ? ~(one << s) : 4'hf;
      check_eq("c_seg", 32'(seg_c), 32'(exp_seg));
      check_eq("c_dig", 32'(dig_c), 32'(exp_dig));
`endif
      c = k % 2;
      s = (k / 2) % 4;
      lit     = (c >= 1);
      exp_seg = lit ? snap_b[s] : 7'h7f;
      exp_dig = lit ? ~(one << s) : 4'hf;
      check_eq("b_seg", 32'(seg_b), 32'(exp_seg));
      check_eq("b_dig", 32'(dig_b), 32'(exp_dig));
      check_eq("b_tick", 32'(tick_b), 32'(k % 8 == 0));
    end
  endtask

  initial begin
    rst    = 1'b1;
    hex[0] = 7'h40;
    hex[1] = 7'h79;
    hex[2] = 7'h24;
    hex[3] = 7'h30;
    prev_dig_a = 4'hf;
    repeat (3) @(negedge cpu_clk);
    check_eq("rst_seg", 32'(seg_a), 32'h7f);
    check_eq("rst_dig", 32'(dig_a), 32'hf);
    check_eq("rst_tick", 32'(tick_a), 32'h0);
    rst = 1'b0;

    // Frame 0 up to clk 12, then change hex2 mid-frame.
    run_span(0, 12);
    hex[2] = 7'h00;
    run_span(13, 20);
    check_eq("t2_old_digit2", 32'(seg_a), 32'h24);
    check_eq("t2_old_dig", 32'(dig_a), 32'b1011);
    run_span(21, 52);
    check_eq("t2_new_digit2", 32'(seg_a), 32'h00);
    check_eq("t1_digit2_dig", 32'(dig_a), 32'b1011);
    run_span(53, 66);
    check_eq("t1_repeat_d0", 32'(seg_a), 32'h40);
    check_eq("t1_repeat_dig", 32'(dig_a), 32'b1110);
    run_span(67, 84);
    check_eq("t3_pre_rst_seg", 32'(seg_a), 32'h00);

    // Asynchronous reset mid-slot: outputs must drop before the next clock edge.
    #1;
    rst = 1'b1;
    #1;
    check_eq("t3_async_seg", 32'(seg_a), 32'h7f);
    check_eq("t3_async_dig", 32'(dig_a), 32'hf);
    check_eq("t3_async_seg_b", 32'(seg_b), 32'h7f);
    check_eq("t3_async_dig_b", 32'(dig_b), 32'hf);
    repeat (2) @(negedge cpu_clk);
    rst = 1'b0;
    prev_dig_a = 4'hf;
    run_span(0, 2);
    check_eq("t3_restart_d0", 32'(seg_a), 32'h40);
    check_eq("t3_restart_dig", 32'(dig_a), 32'b1110);
    run_span(3, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
